rgb_led_arbiter: RTL and testbench

Shares the single on-board RGB LED driver between several LED-producing sources (blinky controller, button feedback, DIP-switch status display) and generates the dimmed per-channel PWM enables that feed the SB_RGBA_DRV primitive's RGB0PWM/RGB1PWM/RGB2PWM inputs. It sits in the top level between the HFOSC-clocked controllers and the hard LED driver. It replaces ad-hoc dimming counters with one fixed-priority arbiter, a minimum-hold timer and a shared PWM dimmer.

---
 rtl/rgb_led_arbiter_if.sv | 25 ++
 rtl/rgb_led_arbiter.sv | 101 ++++++++++
 tb/tb_rgb_led_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_led_arbiter_if.sv
// Bundle between LED-producing requesters and the RGB LED arbiter.
// The master side raises requests; the slave side grants and dims the LED.
interface rgb_led_arbiter_if #(
    parameter int NUM_REQ  = 3,
    parameter int PWM_BITS = 3
);
    logic [NUM_REQ-1:0]          i_req;
    logic [3*NUM_REQ-1:0]        i_color;
    logic [PWM_BITS*NUM_REQ-1:0] i_level;
    logic [NUM_REQ-1:0]          o_grant;
    logic                        o_pwm_r;
    logic                        o_pwm_g;
    logic                        o_pwm_b;
    logic                        o_busy;

    modport master (
        output i_req, i_color, i_level,
        input  o_grant, o_pwm_r, o_pwm_g, o_pwm_b, o_busy
    );

    modport slave (
        input  i_req, i_color, i_level,
        output o_grant, o_pwm_r, o_pwm_g, o_pwm_b, o_busy
    );
endinterface

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority owner of the on-board RGB LED with minimum hold time
// and a shared free-running PWM dimmer feeding the hard LED driver.
module rgb_led_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int PWM_BITS = 3,
    parameter int MIN_HOLD = 1024
) (
    input logic               i_clk,
    input logic               i_rst,
    rgb_led_arbiter_if.slave  bus
);
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, BLANK} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  pick;
    logic [NUM_REQ-1:0]  lower;
    logic [HW-1:0]       hold_ctr;
    logic [PWM_BITS-1:0] pwm_ctr;
    logic [PWM_BITS-1:0] owner_level;
    logic [2:0]          owner_color;
    logic                owner_req;
    logic                any_req;
    logic                lit;
    logic                pwm_r;
    logic                pwm_g;
    logic                pwm_b;
    logic                busy;

    // Isolate the lowest set request bit; lower-index mask from one-hot grant.
    assign any_req   = |bus.i_req;
    assign pick      = bus.i_req & (~bus.i_req + NUM_REQ'(1));
    assign lower     = bus.i_req & (grant - NUM_REQ'(1));
    assign owner_req = |(bus.i_req & grant);
    assign lit       = (state == GRANT) && (pwm_ctr < owner_level);

    always_comb begin
        owner_color = '0;
        owner_level = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant[n]) begin
                owner_color = bus.i_color[3*n +: 3];
                owner_level = bus.i_level[PWM_BITS*n +: PWM_BITS];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            grant    <= '0;
            hold_ctr <= '0;
            pwm_ctr  <= '0;
            pwm_r    <= 1'b0;
            pwm_g    <= 1'b0;
            pwm_b    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pwm_ctr <= pwm_ctr + PWM_BITS'(1);
            pwm_r   <= lit & owner_color[2];
            pwm_g   <= lit & owner_color[1];
            pwm_b   <= lit & owner_color[0];
            unique case (state)
                IDLE, BLANK: begin
                    if (any_req) begin
                        state    <= GRANT;
                        grant    <= pick;
                        hold_ctr <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release wins over preemption when both occur together.
                    if (!owner_req || ((|lower) && hold_ctr == HOLD_MAX)) begin
                        state <= BLANK;
                        grant <= '0;
                    end else if (hold_ctr != HOLD_MAX) begin
                        hold_ctr <= hold_ctr + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_grant = grant;
    assign bus.o_pwm_r = pwm_r;
    assign bus.o_pwm_g = pwm_g;
    assign bus.o_pwm_b = pwm_b;
    assign bus.o_busy  = busy;
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Randomized and directed bench for rgb_led_arbiter against an
// owner/blank/hold-count reference model derived from the arbitration rules.
module tb_rgb_led_arbiter;
    localparam int N  = 3;
    localparam int PB = 3;
    localparam int MH = 8;
    localparam int PERIOD = 1 << PB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rgb_led_arbiter_if #(.NUM_REQ(N), .PWM_BITS(PB)) bus ();

    rgb_led_arbiter #(
        .NUM_REQ (N),
        .PWM_BITS(PB),
        .MIN_HOLD(MH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int owner = -1;
    bit blank = 1'b0;
    int held  = 0;
    int cyc   = 0;

    logic [N-1:0] exp_grant = '0;
    bit exp_r = 1'b0;
    bit exp_g = 1'b0;
    bit exp_b = 1'b0;
    bit exp_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int lowest(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1;
        blank = 1'b0;
        held  = 0;
        cyc   = 0;
        exp_grant = '0;
        exp_r = 1'b0;
        exp_g = 1'b0;
        exp_b = 1'b0;
        exp_busy = 1'b0;
    endtask

    // One clock edge of behaviour, using the inputs present at that edge.
    task automatic model_step();
        logic [2:0] c;
        int lv;
        int lo;
        exp_r = 1'b0;
        exp_g = 1'b0;
        exp_b = 1'b0;
        if (owner >= 0) begin
            c  = bus.i_color[3*owner +: 3];
            lv = int'(bus.i_level[PB*owner +: PB]);
            if ((cyc % PERIOD) < lv) begin
                exp_r = c[2];
                exp_g = c[1];
                exp_b = c[0];
            end
        end
        lo = lowest(bus.i_req);
        if (owner >= 0) begin
            if (!bus.i_req[owner] || (lo >= 0 && lo < owner && held >= MH)) begin
                owner = -1;
                blank = 1'b1;
            end else begin
                held++;
            end
        end else begin
            if (lo >= 0) begin
                owner = lo;
                held  = 0;
            end
            blank = 1'b0;
        end
        cyc++;
        exp_grant = '0;
        if (owner >= 0) exp_grant[owner] = 1'b1;
        exp_busy = (owner >= 0) || blank;
    endtask

    task automatic check_outs();
        chk("grant", 32'(bus.o_grant), 32'(exp_grant));
        chk("pwm_r", 32'(bus.o_pwm_r), 32'(exp_r));
        chk("pwm_g", 32'(bus.o_pwm_g), 32'(exp_g));
        chk("pwm_b", 32'(bus.o_pwm_b), 32'(exp_b));
        chk("busy",  32'(bus.o_busy),  32'(exp_busy));
    endtask

    // Advance one edge, update the model, compare, return at the negedge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1 check_outs();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [3*N-1:0] c,
                         input logic [PB*N-1:0] l);
        bus.i_req   = r;
        bus.i_color = c;
        bus.i_level = l;
    endtask

    initial begin
        int n;
        int cnt;
        bit seen;
        drive(3'($urandom), '0, '0);
        repeat (3) begin
            step();
            bus.i_req = 3'($urandom);
        end
        rst = 1'b0;
        bus.i_req = '0;
        repeat (3) step();

        // Single request: red at level 3 on requester 1.
        drive(3'b010, 9'b000_100_000, 9'b000_011_000);
        repeat (20) step();
        bus.i_req = '0;
        repeat (3) step();

        // Release with two higher/lower contenders pending.
        drive(3'b010, 9'b111_111_111, 9'b101_110_111);
        repeat (3) step();
        bus.i_req = 3'b101;
        repeat (4) step();
        bus.i_req = '0;
        repeat (3) step();

        // Hold protection: requester 0 arrives at hold_ctr == 3.
        drive(3'b100, 9'b001_010_100, 9'b111_111_111);
        repeat (4) step();
        bus.i_req = 3'b101;
        n = 0;
        while (n < 40 && bus.o_grant !== 3'b001) begin
            step();
            n++;
        end
        chk("preempt_lat", 32'(n), 32'd7);
        bus.i_req = 3'b001;
        repeat (2) step();
        bus.i_req = 3'b101;
        repeat (15) step();
        chk("no_preempt", 32'(bus.o_grant), 32'b001);
        bus.i_req = '0;
        repeat (3) step();

        // Level extremes on requester 0.
        drive(3'b001, 9'b000_000_111, 9'b000_000_000);
        repeat (2) step();
        cnt = 0;
        repeat (PERIOD) begin
            step();
            cnt += int'(bus.o_pwm_r) + int'(bus.o_pwm_g) + int'(bus.o_pwm_b);
        end
        chk("level0", 32'(cnt), 32'd0);
        drive(3'b001, 9'b000_000_010, 9'b000_000_111);
        repeat (2) step();
        cnt = 0;
        repeat (PERIOD) begin
            step();
            cnt += int'(bus.o_pwm_g);
        end
        chk("level7", 32'(cnt), 32'd7);

        // Asynchronous reset while green is lit.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (exp_g) seen = 1'b1;
            else step();
        end
        chk("pre_rst_g", 32'(bus.o_pwm_g), 32'd1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outs();
        @(negedge clk);
        step();
        rst = 1'b0;
        step();
        chk("reacquire", 32'(bus.o_grant), 32'b001);
        bus.i_req = '0;
        repeat (3) step();

        // Random traffic with slowly changing requests, live color/level.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0) bus.i_req[b] = ~bus.i_req[b];
            bus.i_color = 9'($urandom);
            bus.i_level = 9'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
